// File: rtl/n64adv_vdemux_pkg.sv
// rtl/n64adv_vdemux_pkg.sv - shared phase encodings, mode struct and pix_o field offsets for the VD demux
package n64adv_vdemux_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_R    = 3'd1,
        PH_G    = 3'd2,
        PH_B    = 3'd3,
        PH_DONE = 3'd4,
        PH_OVR  = 3'd5
    } phase_e;

    typedef struct packed {
        logic pal;
        logic ndeblur;
        logic n16bit;
    } mode_t;

    // MSB index of each pix_o field; every field below it is COLOR_W wide
    function automatic int SY(input int cw);
        return 3 * cw + 3;
    endfunction

    function automatic int RE(input int cw);
        return 3 * cw - 1;
    endfunction

    function automatic int GR(input int cw);
        return 2 * cw - 1;
    endfunction

    function automatic int BL(input int cw);
        return cw - 1;
    endfunction

endpackage

// File: rtl/n64a_vdemux_lockmon.sv
// rtl/n64a_vdemux_lockmon.sv - framing lock monitor and saturating framing-error counter
module n64a_vdemux_lockmon #(
    parameter int LOCK_CNT = 8,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             good_i,
    input  logic             err_i,
    output logic             lock_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);

    logic [GW-1:0]    good_q, good_d;
    logic             lock_q, lock_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        good_d = good_q;
        cnt_d  = cnt_q;
        if (err_i) begin
            good_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + ERR_W'(1);
            end
        end else if (good_i && (good_q != GOOD_MAX)) begin
            good_d = good_q + GW'(1);
        end
        lock_d = (good_d == GOOD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_q <= '0;
            lock_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            good_q <= good_d;
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lock_o    = lock_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: rtl/n64a_vdemux_gen.sv
// rtl/n64a_vdemux_gen.sv - N64 VD bus demux: sync/R/G/B words to one pixel with truncation, deblur and lock monitor
module n64a_vdemux_gen
    import n64adv_vdemux_pkg::*;
#(
    parameter int COLOR_W  = 7,
    parameter int TRUNC_RB = 2,
    parameter int TRUNC_G  = 1,
    parameter int LOCK_CNT = 8,
    parameter int ERR_W    = 8
) (
    input  logic                 VCLK,
    input  logic                 RST,
    input  logic                 nVDSYNC,
    input  logic [COLOR_W-1:0]   VD_i,
    input  logic                 palmode_i,
    input  logic                 ndeblur_i,
    input  logic                 n16bit_i,
    output logic                 sync_valid_o,
    output logic [3:0]           sync_o,
    output logic                 pix_valid_o,
    output logic [3*COLOR_W+3:0] pix_o,
    output logic                 lock_o,
    output logic                 err_o,
    output logic [ERR_W-1:0]     err_cnt_o
);

    localparam int RGB_MSB = RE(COLOR_W);
    localparam logic [COLOR_W-1:0] ONES    = '1;
    localparam logic [COLOR_W-1:0] MASK_RB = ONES << TRUNC_RB;
    localparam logic [COLOR_W-1:0] MASK_G  = ONES << TRUNC_G;

    phase_e               phase_q, phase_d;
    logic [3:0]           sync_buf_q, sync_buf_d;
    logic                 csync_prev_q, csync_prev_d;
    mode_t                mode_q, mode_d;
    logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic                 nblank_q, nblank_d;
    logic                 sync_valid_q, sync_valid_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [3*COLOR_W+3:0] pix_q, pix_d;
    logic                 err_q, err_d;
    logic                 good_stb;
    logic [COLOR_W-1:0]   chan;

    always_comb begin
        phase_d      = phase_q;
        sync_buf_d   = sync_buf_q;
        csync_prev_d = csync_prev_q;
        mode_d       = mode_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        nblank_d     = nblank_q;
        sync_valid_d = 1'b0;
        pix_valid_d  = 1'b0;
        pix_d        = pix_q;
        err_d        = 1'b0;
        good_stb     = 1'b0;

        chan = mode_q.n16bit ? VD_i : (VD_i & ((phase_q == PH_G) ? MASK_G : MASK_RB));

        // Blanking phase is settled the cycle after a sync, once its mode and nCSYNC are latched
        if (sync_valid_q) begin
            if (mode_q.ndeblur) begin
                nblank_d = 1'b1;
            end else if (sync_buf_q[0] && !csync_prev_q) begin
                nblank_d = mode_q.pal;
            end else begin
                nblank_d = ~nblank_q;
            end
        end

        if (!nVDSYNC) begin
            sync_buf_d   = VD_i[3:0];
            csync_prev_d = sync_buf_q[0];
            mode_d       = '{pal: palmode_i, ndeblur: ndeblur_i, n16bit: n16bit_i};
            sync_valid_d = 1'b1;
            phase_d      = PH_R;
            case (phase_q)
                PH_DONE: begin
                    pix_valid_d = 1'b1;
                    good_stb    = 1'b1;
                    pix_d = {sync_buf_q, nblank_q ? {r_q, g_q, b_q} : pix_q[RGB_MSB -: 3*COLOR_W]};
                end
                PH_R, PH_G, PH_B: err_d = 1'b1;
                default: ;
            endcase
        end else begin
            case (phase_q)
                PH_R: begin
                    r_d     = chan;
                    phase_d = PH_G;
                end
                PH_G: begin
                    g_d     = chan;
                    phase_d = PH_B;
                end
                PH_B: begin
                    b_d     = chan;
                    phase_d = PH_DONE;
                end
                PH_DONE: begin
                    phase_d = PH_OVR;
                    err_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            phase_q      <= PH_IDLE;
            sync_buf_q   <= '0;
            csync_prev_q <= 1'b0;
            mode_q       <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            nblank_q     <= 1'b1;
            sync_valid_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            sync_buf_q   <= sync_buf_d;
            csync_prev_q <= csync_prev_d;
            mode_q       <= mode_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            nblank_q     <= nblank_d;
            sync_valid_q <= sync_valid_d;
            pix_valid_q  <= pix_valid_d;
            pix_q        <= pix_d;
            err_q        <= err_d;
        end
    end

    n64a_vdemux_lockmon #(
        .LOCK_CNT(LOCK_CNT),
        .ERR_W   (ERR_W)
    ) u_lockmon (
        .clk      (VCLK),
        .rst      (RST),
        .good_i   (good_stb),
        .err_i    (err_d),
        .lock_o   (lock_o),
        .err_cnt_o(err_cnt_o)
    );

    assign sync_valid_o = sync_valid_q;
    assign sync_o       = sync_buf_q;
    assign pix_valid_o  = pix_valid_q;
    assign pix_o        = pix_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_n64a_vdemux_gen.sv
// tb/tb_n64a_vdemux_gen.sv - directed scoreboard bench for n64a_vdemux_gen
module tb_n64a_vdemux_gen;

    logic        VCLK;
    logic        RST;
    logic        nVDSYNC;
    logic [6:0]  VD_i;
    logic        palmode_i;
    logic        ndeblur_i;
    logic        n16bit_i;
    logic        sync_valid_o;
    logic [3:0]  sync_o;
    logic        pix_valid_o;
    logic [24:0] pix_o;
    logic        lock_o;
    logic        err_o;
    logic [1:0]  err_cnt_o;

    n64a_vdemux_gen #(
        .COLOR_W (7),
        .TRUNC_RB(2),
        .TRUNC_G (1),
        .LOCK_CNT(8),
        .ERR_W   (2)
    ) dut (
        .VCLK        (VCLK),
        .RST         (RST),
        .nVDSYNC     (nVDSYNC),
        .VD_i        (VD_i),
        .palmode_i   (palmode_i),
        .ndeblur_i   (ndeblur_i),
        .n16bit_i    (n16bit_i),
        .sync_valid_o(sync_valid_o),
        .sync_o      (sync_o),
        .pix_valid_o (pix_valid_o),
        .pix_o       (pix_o),
        .lock_o      (lock_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    typedef struct {
        logic [24:0] pix;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    logic        have_prev = 1'b0;
    logic        pend_hold = 1'b0;
    logic [3:0]  pend_sy = '0;
    logic [20:0] pend_rgb = '0;
    logic [20:0] last_rgb = '0;

    initial begin
        VCLK = 1'b0;
        forever #5 VCLK = ~VCLK;
    end

    always @(posedge VCLK) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge VCLK);
            if (sb.size() != 0 && sb[0].due < cyc_n) begin
                chk("pix_missing", 32'(sb[0].due), 32'(cyc_n));
                void'(sb.pop_front());
            end
            if (pix_valid_o === 1'b1) begin
                chk("pix_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pix_o", {7'd0, pix_o}, {7'd0, e.pix});
                    chk("pix_latency", 32'(cyc_n), 32'(e.due));
                end
            end
        end
    end

    task automatic step(input logic nv, input logic [6:0] d);
        nVDSYNC = nv;
        VD_i    = d;
        @(posedge VCLK);
        #1;
    endtask

    task automatic period(input logic [3:0] sy, input logic [6:0] r, input logic [6:0] g,
                          input logic [6:0] b, input int nwords, input logic n16, input logic mid,
                          input logic hold, input logic exp_err, input int exp_cnt);
        exp_t        e;
        logic [20:0] rgb;
        if (have_prev) begin
            rgb      = pend_hold ? last_rgb : pend_rgb;
            last_rgb = rgb;
            e.pix    = {pend_sy, rgb};
            e.due    = cyc_n + 1;
            sb.push_back(e);
        end
        n16bit_i = n16;
        step(1'b0, {3'b000, sy});
        chk("sync_valid", 32'(sync_valid_o), 32'd1);
        chk("sync_o", 32'(sync_o), 32'(sy));
        chk("err_at_sync", 32'(err_o), 32'(exp_err));
        chk("err_cnt", 32'(err_cnt_o), 32'(exp_cnt));
        n16bit_i = mid;
        for (int k = 0; k < nwords; k++) begin
            step(1'b1, (k == 0) ? r : (k == 1) ? g : (k == 2) ? b : 7'h00);
            if (k == 0) chk("sync_strobe", 32'(sync_valid_o), 32'd0);
            if (k == 3) chk("ovr_err", 32'(err_o), 32'd1);
            if (k == 4) chk("ovr_once", 32'(err_o), 32'd0);
        end
        have_prev = (nwords == 3);
        pend_sy   = sy;
        pend_hold = hold;
        pend_rgb  = {n16 ? r : (r & 7'h7C), n16 ? g : (g & 7'h7E), n16 ? b : (b & 7'h7C)};
    endtask

    initial begin
        RST = 1'b1; nVDSYNC = 1'b1; VD_i = '0;
        palmode_i = 1'b0; ndeblur_i = 1'b1; n16bit_i = 1'b1;
        repeat (3) @(posedge VCLK);
        #1;
        chk("rst_sync_valid", 32'(sync_valid_o), 32'd0);
        chk("rst_sync_o", 32'(sync_o), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
        chk("rst_pix_o", {7'd0, pix_o}, 32'd0);
        chk("rst_lock", 32'(lock_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        RST = 1'b0;

        // ten well-formed periods; lock after eight emitted pixels
        for (int i = 0; i < 10; i++) begin
            period(4'hF, 7'h55, 7'h2A, 7'h7F, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            chk("lock_ramp", 32'(lock_o), 32'(i >= 8));
        end

        // truncation and mid-pixel n16bit toggles
        period(4'h5, 7'h7F, 7'h7F, 7'h7F, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        period(4'h5, 7'h7F, 7'h7F, 7'h7F, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        period(4'h5, 7'h7F, 7'h7F, 7'h7F, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("lock_held", 32'(lock_o), 32'd1);

        // short period
        period(4'hA, 7'h11, 7'h22, 7'h00, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        period(4'h3, 7'h31, 7'h32, 7'h33, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        chk("lock_after_err", 32'(lock_o), 32'd0);

        // long period: six cycles between syncs
        period(4'hC, 7'h41, 7'h42, 7'h43, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("lock_after_ovr", 32'(lock_o), 32'd0);
        period(4'h6, 7'h61, 7'h62, 7'h63, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2);

        // deblur with an nCSYNC 0->1 edge at D1
        ndeblur_i = 1'b0;
        period(4'hE, 7'h01, 7'h02, 7'h03, 3, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        period(4'hF, 7'h11, 7'h12, 7'h13, 3, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        period(4'hF, 7'h21, 7'h22, 7'h23, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        period(4'hF, 7'h31, 7'h32, 7'h33, 3, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        period(4'hF, 7'h41, 7'h42, 7'h43, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        ndeblur_i = 1'b1;
        period(4'hF, 7'h51, 7'h52, 7'h53, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2);

        // error counter saturation
        period(4'h1, 7'h01, 7'h00, 7'h00, 1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        period(4'h2, 7'h01, 7'h00, 7'h00, 1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        period(4'h3, 7'h01, 7'h00, 7'h00, 1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        period(4'h4, 7'h01, 7'h00, 7'h00, 1, 1'b1, 1'b1, 1'b0, 1'b1, 3);

        // reset mid-pixel
        RST = 1'b1;
        step(1'b1, 7'h00);
        chk("mid_rst_sync_valid", 32'(sync_valid_o), 32'd0);
        chk("mid_rst_sync_o", 32'(sync_o), 32'd0);
        chk("mid_rst_pix_valid", 32'(pix_valid_o), 32'd0);
        chk("mid_rst_pix_o", {7'd0, pix_o}, 32'd0);
        chk("mid_rst_lock", 32'(lock_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt_o), 32'd0);
        RST = 1'b0;
        have_prev = 1'b0;
        last_rgb  = '0;

        period(4'h9, 7'h0A, 7'h0B, 7'h0C, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        period(4'h7, 7'h1A, 7'h1B, 7'h1C, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        period(4'h5, 7'h2A, 7'h2B, 7'h2C, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) step(1'b1, 7'h00);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
